// File: rtl/servo_pkg.sv
// Shared encodings and command field layout for the servo command path.
`timescale 1ns/1ps
package servo_pkg;

  // Receiver states; the value is also the debug display code.
  typedef enum logic [3:0] {
    RX_INICIAL  = 4'b0000,
    RX_INICIO   = 4'b0001,
    RX_DADOS    = 4'b0010,
    RX_PARADA   = 4'b0011,
    RX_ARMAZENA = 4'b0100
  } estado_rx_t;

  typedef enum logic [1:0] {
    CMD_OCIOSO  = 2'b00,
    CMD_DISPARA = 2'b01,
    CMD_ESPERA  = 2'b10
  } estado_cmd_t;

  localparam logic [3:0] DB_ILEGAL = 4'b1110;

  // Command byte layout: [7:5] id, [4:3] sentido, [2:0] must be zero.
  localparam int unsigned ID_MSB      = 7;
  localparam int unsigned ID_LSB      = 5;
  localparam int unsigned SENTIDO_MSB = 4;
  localparam int unsigned SENTIDO_LSB = 3;
  localparam int unsigned ZERO_MSB    = 2;

  localparam logic [1:0] GIRO_90_HORARIO = 2'b00;
  localparam logic [1:0] GIRO_90_ANTI    = 2'b01;
  localparam logic [1:0] GIRO_180        = 2'b10;

  // Debug code for a receiver state; anything unexpected shows as 1110.
  function automatic logic [3:0] codigo_db(input estado_rx_t e);
    logic [3:0] codigo;
    case (e)
      RX_INICIAL, RX_INICIO, RX_DADOS, RX_PARADA, RX_ARMAZENA: codigo = 4'(e);
      default: codigo = DB_ILEGAL;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/serial_rx_8n1.sv
// 8N1 serial receiver: input synchronizer, bit timer and framing FSM.
`timescale 1ns/1ps
module serial_rx_8n1
  import servo_pkg::*;
#(
  parameter int unsigned CICLOS_POR_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dado,
  output logic       valido,
  output logic       erro_quadro,
  output logic [3:0] db_estado
);

  localparam int unsigned W_CONT = $clog2(CICLOS_POR_BIT);
  localparam logic [W_CONT-1:0] FIM_BIT  = W_CONT'(CICLOS_POR_BIT - 1);
  localparam logic [W_CONT-1:0] FIM_MEIO = W_CONT'(CICLOS_POR_BIT / 2 - 1);

  logic              rx_meta;
  logic              rx_sinc;
  logic              rx_ant;
  logic              borda_descida;
  estado_rx_t        estado;
  logic [W_CONT-1:0] contador;
  logic [2:0]        n_bits;

  assign borda_descida = rx_ant & ~rx_sinc;
  assign db_estado     = codigo_db(estado);

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sinc <= 1'b1;
      rx_ant  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sinc <= rx_meta;
      rx_ant  <= rx_sinc;
    end
  end

  // Framing FSM: mid-bit sampling of start, 8 data bits LSB first, stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= RX_INICIAL;
      contador    <= '0;
      n_bits      <= '0;
      dado        <= '0;
      valido      <= 1'b0;
      erro_quadro <= 1'b0;
    end else begin
      valido      <= 1'b0;
      erro_quadro <= 1'b0;
      case (estado)
        RX_INICIAL: begin
          contador <= '0;
          if (borda_descida) estado <= RX_INICIO;
        end
        RX_INICIO: begin
          if (contador == FIM_MEIO) begin
            contador <= '0;
            n_bits   <= '0;
            estado   <= rx_sinc ? RX_INICIAL : RX_DADOS;
          end else begin
            contador <= contador + W_CONT'(1);
          end
        end
        RX_DADOS: begin
          if (contador == FIM_BIT) begin
            contador <= '0;
            dado     <= {rx_sinc, dado[7:1]};
            if (n_bits == 3'd7) estado <= RX_PARADA;
            else                n_bits <= n_bits + 3'd1;
          end else begin
            contador <= contador + W_CONT'(1);
          end
        end
        RX_PARADA: begin
          if (contador == FIM_BIT) begin
            contador <= '0;
            if (rx_sinc) begin
              estado <= RX_ARMAZENA;
              valido <= 1'b1;
            end else begin
              estado      <= RX_INICIAL;
              erro_quadro <= 1'b1;
            end
          end else begin
            contador <= contador + W_CONT'(1);
          end
        end
        RX_ARMAZENA: estado <= RX_INICIAL;
        default:     estado <= RX_INICIAL;
      endcase
    end
  end

endmodule

// File: rtl/servo_comando_rx.sv
// Servo command receiver: decodes serial bytes, buffers one, dispatches starts.
`timescale 1ns/1ps
module servo_comando_rx
  import servo_pkg::*;
#(
  parameter int unsigned CICLOS_POR_BIT = 434,
  parameter int unsigned N_SERVOS       = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic [N_SERVOS-1:0] pronto_servo,
  output logic [N_SERVOS-1:0] iniciar_servo,
  output logic [1:0]          sentido,
  output logic                ocupado,
  output logic                erro_quadro,
  output logic                erro_comando,
  output logic                sobrecarga,
  output logic [3:0]          db_estado
);

  logic [7:0]          dado;
  logic                valido;
  logic [2:0]          cmd_id;
  logic [1:0]          cmd_sentido;
  logic                cmd_legal_c;
  logic                valido_legal;
  logic                buf_valido;
  logic [2:0]          buf_id;
  logic [1:0]          buf_sentido;
  logic [2:0]          disp_id;
  logic [1:0]          disp_sentido;
  logic [N_SERVOS-1:0] mascara_ativa;
  estado_cmd_t         estado_cmd;

  function automatic logic [N_SERVOS-1:0] um_quente(input logic [2:0] id);
    return N_SERVOS'(1) << id;
  endfunction

  serial_rx_8n1 #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) u_serial (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .dado       (dado),
    .valido     (valido),
    .erro_quadro(erro_quadro),
    .db_estado  (db_estado)
  );

  assign cmd_id       = dado[ID_MSB:ID_LSB];
  assign cmd_sentido  = dado[SENTIDO_MSB:SENTIDO_LSB];
  assign cmd_legal_c  = (32'(cmd_id) < N_SERVOS) &&
                        (cmd_sentido inside {GIRO_90_HORARIO, GIRO_90_ANTI, GIRO_180}) &&
                        (dado[ZERO_MSB:0] == 3'b000);
  assign valido_legal = valido & cmd_legal_c;

  // A waiting buffered command always goes before a freshly received one.
  assign disp_id      = buf_valido ? buf_id      : cmd_id;
  assign disp_sentido = buf_valido ? buf_sentido : cmd_sentido;

  // Command FSM, one-entry buffer and error/overflow pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_cmd    <= CMD_OCIOSO;
      iniciar_servo <= '0;
      mascara_ativa <= '0;
      sentido       <= 2'b00;
      ocupado       <= 1'b0;
      erro_comando  <= 1'b0;
      sobrecarga    <= 1'b0;
      buf_valido    <= 1'b0;
      buf_id        <= '0;
      buf_sentido   <= '0;
    end else begin
      iniciar_servo <= '0;
      sobrecarga    <= 1'b0;
      erro_comando  <= valido & ~cmd_legal_c;

      case (estado_cmd)
        CMD_OCIOSO: begin
          if (buf_valido || valido_legal) begin
            estado_cmd    <= CMD_DISPARA;
            iniciar_servo <= um_quente(disp_id);
            mascara_ativa <= um_quente(disp_id);
            sentido       <= disp_sentido;
            ocupado       <= 1'b1;
          end
          if (buf_valido && !valido_legal) buf_valido <= 1'b0;
        end
        CMD_DISPARA: estado_cmd <= CMD_ESPERA;
        CMD_ESPERA: begin
          if (|(pronto_servo & mascara_ativa)) begin
            estado_cmd <= CMD_OCIOSO;
            ocupado    <= 1'b0;
          end
        end
        default: begin
          estado_cmd <= CMD_OCIOSO;
          ocupado    <= 1'b0;
        end
      endcase

      // While idle with a buffered entry, the new byte refills the slot being drained.
      if (valido_legal) begin
        if (estado_cmd == CMD_OCIOSO) begin
          if (buf_valido) begin
            buf_id      <= cmd_id;
            buf_sentido <= cmd_sentido;
          end
        end else if (!buf_valido) begin
          buf_valido  <= 1'b1;
          buf_id      <= cmd_id;
          buf_sentido <= cmd_sentido;
        end else begin
          sobrecarga <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_comando_rx.sv
// Scoreboard bench for servo_comando_rx with directed serial frames.
`timescale 1ns/1ps
module tb_servo_comando_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned NS  = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx    = 1'b1;
  logic [NS-1:0] pronto_servo = '0;
  logic [NS-1:0] iniciar_servo;
  logic [1:0]    sentido;
  logic          ocupado;
  logic          erro_quadro;
  logic          erro_comando;
  logic          sobrecarga;
  logic [3:0]    db_estado;

  servo_comando_rx #(
    .CICLOS_POR_BIT(CPB),
    .N_SERVOS      (NS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .pronto_servo (pronto_servo),
    .iniciar_servo(iniciar_servo),
    .sentido      (sentido),
    .ocupado      (ocupado),
    .erro_quadro  (erro_quadro),
    .erro_comando (erro_comando),
    .sobrecarga   (sobrecarga),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [NS-1:0] ini;
    logic [1:0]    sen;
    logic          eq;
    logic          ec;
    logic          sob;
  } evento_t;

  evento_t     fila[$];
  evento_t     ev_atual;
  evento_t     ev_esp;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc_ultimo_ini = 0;
  int unsigned cyc_pronto     = 0;

  task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  function automatic evento_t ev_ini(input int id, input logic [1:0] s);
    evento_t e;
    e = '0;
    e.ini = NS'(1) << id;
    e.sen = s;
    return e;
  endfunction

  function automatic evento_t ev_flag(input logic eq, input logic ec, input logic sob);
    evento_t e;
    e = '0;
    e.eq  = eq;
    e.ec  = ec;
    e.sob = sob;
    return e;
  endfunction

  // Monitor: every cycle an output event appears, compare it with the next expected one.
  always @(negedge clock) begin
    if (!reset && ((|iniciar_servo) || erro_quadro || erro_comando || sobrecarga)) begin
      ev_atual = {iniciar_servo, ((|iniciar_servo) ? sentido : 2'b00),
                  erro_quadro, erro_comando, sobrecarga};
      if (|iniciar_servo) begin
        cyc_ultimo_ini = cyc;
        verifica("ocupado_no_disparo", 32'(ocupado), 32'd1);
      end
      if (fila.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got %h expected none (cycle %0d)", ev_atual, cyc);
      end else begin
        ev_esp = fila.pop_front();
        verifica("evento", 32'(ev_atual), 32'(ev_esp));
      end
    end
  end

  task automatic espera(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bit_serial(input logic v);
    rx = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic envia(input logic [7:0] b, input logic parada_ok);
    bit_serial(1'b0);
    for (int i = 0; i < 8; i++) bit_serial(b[i]);
    bit_serial(parada_ok);
    rx = 1'b1;
  endtask

  // One-cycle pronto pulse; optionally checks ocupado drops the cycle after it.
  task automatic pulso_pronto(input int id, input logic checar);
    pronto_servo = NS'(1) << id;
    cyc_pronto   = cyc;
    @(negedge clock);
    if (checar) verifica("ocupado_no_pronto", 32'(ocupado), 32'd1);
    @(posedge clock);
    #1;
    pronto_servo = '0;
    @(negedge clock);
    if (checar) verifica("ocupado_apos_pronto", 32'(ocupado), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic verifica_reset(input string nome);
    verifica({nome, "_iniciar"}, 32'(iniciar_servo), 32'd0);
    verifica({nome, "_sentido"}, 32'(sentido), 32'd0);
    verifica({nome, "_ocupado"}, 32'(ocupado), 32'd0);
    verifica({nome, "_erros"}, 32'({erro_quadro, erro_comando, sobrecarga}), 32'd0);
    verifica({nome, "_db"}, 32'(db_estado), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    espera(3);
    verifica_reset("reset_inicial");
    reset = 1'b0;
    espera(10);

    // Legal move for servo 2, counter-clockwise.
    fila.push_back(ev_ini(2, 2'b01));
    envia(8'h48, 1'b1);
    espera(50);
    verifica("t1_disparado", 32'(fila.size()), 32'd0);
    verifica("t1_ocupado", 32'(ocupado), 32'd1);
    pulso_pronto(2, 1'b1);
    verifica("t1_sentido_mantido", 32'(sentido), 32'd1);

    // Illegal commands: id 7, sentido 11, nonzero low bits.
    fila.push_back(ev_flag(1'b0, 1'b1, 1'b0));
    envia(8'hE0, 1'b1);
    fila.push_back(ev_flag(1'b0, 1'b1, 1'b0));
    envia(8'h18, 1'b1);
    fila.push_back(ev_flag(1'b0, 1'b1, 1'b0));
    envia(8'h41, 1'b1);
    espera(5);
    verifica("t2_ocioso", 32'(ocupado), 32'd0);

    // Framing error, then a good 180-degree move for servo 0.
    fila.push_back(ev_flag(1'b1, 1'b0, 1'b0));
    envia(8'h00, 1'b0);
    espera(2 * CPB);
    fila.push_back(ev_ini(0, 2'b10));
    envia(8'h10, 1'b1);
    espera(10);
    verifica("t3_sentido", 32'(sentido), 32'd2);
    pulso_pronto(0, 1'b1);

    // Short low glitch is rejected by the start-bit check.
    rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    rx = 1'b1;
    @(negedge clock);
    verifica("t4_db_inicio", 32'(db_estado), 32'd1);
    espera(20);
    verifica("t4_db_volta", 32'(db_estado), 32'd0);

    // Back-to-back: dispatch, buffer, overflow; buffered one at P+2.
    fila.push_back(ev_ini(0, 2'b00));
    fila.push_back(ev_flag(1'b0, 1'b0, 1'b1));
    envia(8'h00, 1'b1);
    envia(8'h20, 1'b1);
    envia(8'h40, 1'b1);
    espera(5);
    pulso_pronto(3, 1'b0);
    verifica("t5_pronto_outro_ignorado", 32'(ocupado), 32'd1);
    fila.push_back(ev_ini(1, 2'b00));
    pulso_pronto(0, 1'b1);
    espera(3);
    verifica("t5_latencia_buffer", cyc_ultimo_ini, cyc_pronto + 2);
    verifica("t5_fila_vazia", 32'(fila.size()), 32'd0);
    pulso_pronto(1, 1'b1);

    // Reset in the middle of the data bits.
    bit_serial(1'b0);
    bit_serial(1'b1);
    bit_serial(1'b0);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    verifica_reset("reset_dados");
    espera(3);
    reset = 1'b0;
    espera(12 * CPB);
    verifica("pos_reset_db", 32'(db_estado), 32'd0);

    // Reset while waiting for pronto with a command buffered.
    fila.push_back(ev_ini(0, 2'b01));
    envia(8'h08, 1'b1);
    envia(8'h28, 1'b1);
    espera(5);
    verifica("t6_ocupado_antes", 32'(ocupado), 32'd1);
    reset = 1'b1;
    #1;
    verifica_reset("reset_espera");
    espera(2);
    reset = 1'b0;
    espera(5);
    pulso_pronto(0, 1'b0);
    espera(4 * CPB);
    verifica("t6_sem_disparo", 32'(ocupado), 32'd0);

    espera(10);
    while (fila.size() > 0) begin
      ev_esp = fila.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event: got none expected %h", ev_esp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
